piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out transmitter: the sending end of our SIPO shift-register link.
//  Captures a WIDTH-bit word on request and shifts it out one bit per clock period.
//  With WIDTH=4, LSB-first, a SIPO4bits on the same C/nCLR holds the word after the last bit.
//  Sits between a parallel data source and the serial line I of the receiving SIPO.
// PARAMETERS
//  WIDTH      4   word length in bits (>=2)
//  MSB_FIRST  0   0: send P[0] first (matches SIPO4bits bit order); 1: send P[WIDTH-1] first
// PORTS
//  C      in   1      clock; all state changes on the falling edge (negedge C)
//  nCLR   in   1      reset, asynchronous, active-low
//  P      in   WIDTH  parallel word, sampled only on an accepted LOAD edge
//  LOAD   in   1      transmit request, sampled on the falling edge of C
//  S      out  1      serial data; each bit held for one full C period
//  BUSY   out  1      high while a word is being shifted out
//  DONE   out  1      one-period pulse after the last bit of a word
// BEHAVIOUR
//  - Reset (nCLR=0, asynchronous): shift reg=0, bit counter=0, state=IDLE, S=0, BUSY=0, DONE=0.
//    Takes effect immediately, including mid-word; the word in flight is discarded and DONE is not raised.
//  - Registers: shift reg [WIDTH-1:0]; counter [$clog2(WIDTH)-1:0]; state {IDLE, SHIFT}; DONE flop.
//  - IDLE: S=0, BUSY=0.
//    Falling edge with LOAD=1: capture P, drive the first bit on S, counter=WIDTH-1, BUSY=1, go to SHIFT.
//  - SHIFT, falling edge with counter!=0:
//    shift toward the output end, drive the next bit on S, counter decrements.
//  - SHIFT, falling edge with counter==0 (end of the last bit): DONE=1 for exactly one period.
//    * LOAD=0: go to IDLE; S=0, BUSY=0.
//    * LOAD=1: back-to-back. Capture the new P and drive its first bit. BUSY stays 1; no idle gap.
//  - LOAD while SHIFT with counter!=0 is ignored; P is not sampled.
//  - DONE is cleared on every falling edge where it is not re-asserted.
//  - Latency: LOAD edge e0 drives bit0; the receiver samples bit k at edge e(k+1).
//    The receiver holds the full word after edge e(WIDTH); DONE=1 in the period after e(WIDTH).
//  - Bit order: MSB_FIRST=0 sends P[0],P[1],..,P[WIDTH-1]; MSB_FIRST=1 reverses it.
//  - Exactly WIDTH bits per word; the counter never wraps past 0 while in SHIFT.
//  - S, BUSY and DONE are registered outputs; no combinational path from inputs to outputs.
// STRUCTURE
//  - Shared header serial_defs.vh: state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1, and the default link WIDTH=4.
//    Include it in both this block and its tests.
//  - Single module. The bit counter and shift register are inline; no sub-module.
//  - The loopback bench instantiates the existing SIPO4bits as the receiver.
// TESTING (WIDTH=4 unless stated; one period = one C cycle)
//  1. Pulse nCLR=0 with LOAD=1 -> S=0, BUSY=0, DONE=0 immediately. Release -> stays IDLE until next LOAD edge.
//  2. P=4'b1011, LOAD for one edge -> S=1,1,0,1 over 4 periods; BUSY=1 for 4 periods.
//     DONE=1 for period 5. Loopback SIPO O=4'b1011 when DONE=1.
//  3. Start P=4'b1011, then LOAD=1 with P=4'b0000 at the 2nd edge -> ignored; S still 1,1,0,1; one DONE pulse.
//  4. LOAD held high, P=4'b1011 then 4'b0110 at the final edge -> S=1,1,0,1,0,1,1,0.
//     BUSY never drops; DONE pulses twice; SIPO shows 1011 then 0110.
//  5. P=4'b1111, assert nCLR after 2 bits -> S=0, BUSY=0 at once, no DONE.
//     After release, LOAD P=4'b0101 -> S=1,0,1,0 and DONE.
//  6. MSB_FIRST=1, P=4'b1000 -> S=1,0,0,0, then S=0 with DONE=1.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serial link: default word length and transmitter state encoding.
package piso_serializer_pkg;

    localparam int LINK_WIDTH = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter feeding the serial input of a SIPO receiver.
// All state advances on the falling edge of C; nCLR clears everything asynchronously.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = LINK_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             C,
    input  logic             nCLR,
    input  logic [WIDTH-1:0] P,
    input  logic             LOAD,
    output logic             S,
    output logic             BUSY,
    output logic             DONE
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;

    // The output-end bit of the shift register is the line itself; clearing the
    // register on the way back to IDLE is what drives the line low between words.
    assign S    = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    assign BUSY = r_busy;
    assign DONE = r_done;

    always_ff @(negedge C or negedge nCLR) begin
        if (!nCLR) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (LOAD) begin
                        r_shift <= P;
                        r_cnt   <= LAST_CNT;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_shift <= MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
                        r_cnt   <= r_cnt - CW'(1);
                    end else begin
                        // Last bit has had its full period; a pending LOAD chains the next word.
                        r_done <= 1'b1;
                        if (LOAD) begin
                            r_shift <= P;
                            r_cnt   <= LAST_CNT;
                        end else begin
                            r_shift <= '0;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
